// File: rtl/pipe_stage_buf.sv
// Pipeline-stage buffer carrying an instruction word and its PC between two stages.
// A two-entry main/skid arrangement keeps in_ready a registered signal; supports stall, flush and bubble counting.
module pipe_stage_buf #(
  parameter int                INST_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic accept;
  logic deliver;

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid_q && out_ready && !stall;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      // Everything buffered or offered this cycle is dropped; out_pc keeps its last value.
      out_valid_d  = 1'b0;
      out_inst_d   = NOP_INST;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_inst_d  = in_inst;
        out_pc_d    = in_pc;
      end
    end else if (!skid_valid_q) begin
      if (accept && deliver) begin
        out_inst_d = in_inst;
        out_pc_d   = in_pc;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = in_inst;
        skid_pc_d    = in_pc;
      end else if (deliver) begin
        out_valid_d = 1'b0;
        out_inst_d  = NOP_INST;
      end
    end else if (deliver) begin
      // Skid beat is always the older one, so it moves up before any new accept.
      out_inst_d   = skid_inst_q;
      out_pc_d     = skid_pc_q;
      skid_valid_d = 1'b0;
    end

    in_ready_d   = !skid_valid_d;
    bubble_cnt_d = out_valid_q ? bubble_cnt_q : sat_inc(bubble_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_inst_q   <= NOP_INST;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      bubble_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Skid payload is qualified by skid_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_inst_q <= skid_inst_d;
    skid_pc_q   <= skid_pc_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_pc     = out_pc_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: queue-based reference model, directed scenarios and random traffic.
module tb_pipe_stage_buf;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, stall, flush;
  logic [31:0] in_inst, in_pc;
  logic        in_ready, out_valid, in_ready_c, out_valid_c;
  logic [31:0] out_inst, out_pc, out_inst_c, out_pc_c;
  logic [15:0] bubble_cnt;
  logic [3:0]  bubble_cnt_c;

  pipe_stage_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .stall(stall), .flush(flush),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_buf #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_inst(out_inst_c), .out_pc(out_pc_c), .stall(stall), .flush(flush),
    .bubble_cnt(bubble_cnt_c)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: FIFO of at most two beats; the head is what the next stage sees.
  logic [31:0] mq_inst[$];
  logic [31:0] mq_pc[$];
  logic [31:0] m_pc    = '0;
  int          m_cnt16 = 0;
  int          m_cnt4  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit deliver, accept;
    if (rst) begin
      mq_inst.delete(); mq_pc.delete();
      m_pc = '0; m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      if (mq_inst.size() == 0) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (flush) begin
        mq_inst.delete(); mq_pc.delete();
      end else begin
        deliver = (mq_inst.size() > 0) && out_ready && !stall;
        accept  = in_valid && (mq_inst.size() < 2);
        if (deliver) begin
          void'(mq_inst.pop_front()); void'(mq_pc.pop_front());
        end
        if (accept) begin
          mq_inst.push_back(in_inst); mq_pc.push_back(in_pc);
        end
      end
      if (mq_pc.size() > 0) m_pc = mq_pc[0];
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, mq_inst.size() > 0);
      check("out_inst", out_inst, (mq_inst.size() > 0) ? mq_inst[0] : NOP);
      check("out_pc", out_pc, m_pc);
      check("in_ready", in_ready, mq_inst.size() < 2);
      check("bubble_cnt", bubble_cnt, m_cnt16);
      check("bubble_cnt4", bubble_cnt_c, m_cnt4);
      check("out_pc_c", out_pc_c, m_pc);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy,
                     input logic st, input logic fl, input logic r);
    in_valid = v; in_pc = pc; in_inst = 32'hA000_0000 | pc;
    out_ready = ordy; stall = st; flush = fl; rst = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    // Reset with a beat offered
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_inst = 32'hDEAD_BEEF; in_pc = 32'h100; rst = 1'b1;
      @(posedge clk); model_edge(); #1;
    end
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 32'h0000_0013);
    check("rst_out_pc", out_pc, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_bubble", bubble_cnt, 0);
    chk_en = 1'b1;

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0, 0);
    check("cnt4_sat", bubble_cnt_c, 15);
    check("cnt16_20", bubble_cnt, 20);
    cyc(0, 0, 1, 0, 0, 1);
    check("cnt4_rst", bubble_cnt_c, 0);

    // Streaming
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'(i * 4), 1, 0, 0, 0);
      check("stream_pc", out_pc, 32'(i * 4));
      check("stream_vld", out_valid, 1);
      check("stream_rdy", in_ready, 1);
    end
    cyc(0, 0, 1, 0, 0, 0);
    check("drain_vld", out_valid, 0);

    // Stall fill then release
    cyc(1, 32'h10, 1, 1, 0, 0);
    cyc(1, 32'h14, 1, 1, 0, 0);
    check("stall_rdy0", in_ready, 0);
    cyc(1, 32'h18, 1, 1, 0, 0);
    check("stall_hold_pc", out_pc, 32'h10);
    cyc(0, 0, 1, 0, 0, 0);
    check("rel_pc1", out_pc, 32'h14);
    check("rel_rdy", in_ready, 1);
    cyc(0, 0, 1, 0, 0, 0);
    check("rel_empty", out_valid, 0);
    check("rel_pc_hold", out_pc, 32'h14);

    // Flush at occupancy 2 with a beat offered
    cyc(1, 32'h30, 1, 1, 0, 0);
    cyc(1, 32'h34, 1, 1, 0, 0);
    cyc(1, 32'h20, 1, 1, 1, 0);
    check("flush_vld", out_valid, 0);
    check("flush_inst", out_inst, 32'h0000_0013);
    check("flush_rdy", in_ready, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    check("flush_nostale", out_valid, 0);

    // Simultaneous accept and deliver at occupancy 1
    cyc(1, 32'h40, 0, 0, 0, 0);
    cyc(1, 32'h44, 1, 0, 0, 0);
    check("ad_pc", out_pc, 32'h44);
    check("ad_rdy", in_ready, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0,
          $urandom_range(0, 150) == 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised successor to the fixed IF/ID pipeline register: a single pipeline-stage buffer carrying an instruction word and its PC between two stages, with valid/ready handshaking on both sides, a two-entry skid so the upstream ready is a registered signal, hazard stall, synchronous flush with NOP bubble injection, and a saturating bubble counter for performance monitoring. It is instantiated between IF and ID, and is reusable between any later pair of stages.

## Interface
Parameters:
- INST_W, 32, instruction word width
- PC_W, 32, PC width
- NOP_INST, 32'h0000_0013, word driven on out_inst whenever out_valid=0 (RV32 addi x0,x0,0)
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  buffer can accept; equals !skid_valid, registered
- in_inst  in  INST_W  upstream instruction
- in_pc  in  PC_W  upstream PC
- out_valid  out  1  out_inst/out_pc hold a live beat
- out_ready  in  1  downstream can take a beat
- out_inst  out  INST_W  instruction to next stage
- out_pc  out  PC_W  PC to next stage
- stall  in  1  hazard hold; forces effective downstream ready low
- flush  in  1  kill all buffered and incoming beats
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0

## Operation
- Accept = in_valid && in_ready. Deliver = out_valid && out_ready && !stall.
- Storage: main register (out_*, out_valid) and skid register (skid_inst, skid_pc, skid_valid). Occupancy is 0, 1 or 2.
- Occupancy 0: accept -> main <= in, occupancy 1.
- Occupancy 1: accept && deliver -> main <= in, occupancy 1. Accept only -> skid <= in, occupancy 2. Deliver only -> out_valid <= 0, out_inst <= NOP_INST, occupancy 0. Neither -> hold.
- Occupancy 2: in_ready=0, so no accept. Deliver -> main <= skid, skid_valid <= 0, occupancy 1. Otherwise hold.
- Order is preserved: the skid beat is always older than any later accept.
- Priority per edge: rst > flush > normal transfer.
- Flush: out_valid <= 0, skid_valid <= 0, out_inst <= NOP_INST, out_pc holds. Any beat offered or delivered in the flush cycle is discarded and not counted as accepted. Stall is ignored.
- Stall with out_ready=1: no deliver. The buffer fills to occupancy 2 and then deasserts in_ready.
- out_pc holds its last value while out_valid=0.
- bubble_cnt increments by 1 on each edge where out_valid=0 (sampled before the edge) and rst=0. It saturates at 2^CNT_W-1 and never wraps. Only rst clears it.

## Timing
- Reset values (after first rst edge): out_valid=0, out_inst=NOP_INST, out_pc=0, skid_valid=0, in_ready=1, bubble_cnt=0. Beats offered while rst=1 are dropped.
- Latency: a beat accepted into an empty buffer appears on out_* the next cycle.
- Throughput: one beat per cycle sustained when out_ready=1 and stall=0.
- in_ready is a flop output with no combinational path from out_ready, stall or flush.
- out_valid, out_inst and out_pc are flop outputs.
- After flush, in_ready=1 and out_valid=0 from the next cycle. The first beat accepted after that appears one cycle later.
- Reset or flush in the middle of a stall drops both entries. No stale beat emerges afterward.

## Test plan
- Reset: hold rst=1 for 2 cycles while in_valid=1, in_inst=32'hDEAD_BEEF -> out_valid=0, out_inst=32'h0000_0013, out_pc=0, in_ready=1, bubble_cnt=0.
- Streaming: send PCs 0x0,0x4,0x8,0xC back-to-back with out_ready=1 -> each appears on out_pc exactly one cycle after acceptance, out_valid continuous, in_ready stays 1.
- Stall fill: stream with stall=1 for 3 cycles -> occupancy reaches 2, in_ready=0 from the cycle after the second accept. On release, outputs appear in order with none lost or duplicated.
- Flush at occupancy 2 while in_valid=1 with PC 0x20 -> next cycle out_valid=0, out_inst=NOP_INST, in_ready=1. PC 0x20 and both buffered beats never appear.
- Simultaneous accept and deliver at occupancy 1 -> occupancy stays 1 and out_pc updates to the new PC.
- Counter: set CNT_W=4 and idle for 20 cycles after reset -> bubble_cnt=15 and holds; rst returns it to 0.
